uart_bus_master: RTL
====================

Name: uart_bus_master

Overview:
- Host-side debug bridge: turns command frames received over UART into picorv32 native-bus read/write transactions.
- Initiator counterpart of the UART memory-mapped responder. Drives mem_valid/mem_addr/mem_wdata/mem_wstrb and consumes mem_ready/mem_rdata.
- Sits between the UART rx/tx byte FIFOs and the SoC bus arbiter. Lets a PC load and peek memory without the CPU running.

Parameters:
- BYTE_TIMEOUT, 100000: idle cycles allowed between bytes of one frame before the partial frame is discarded.
- BUS_TIMEOUT, 1024: cycles mem_valid may wait for mem_ready before the transaction is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte; no backpressure
- rx_data  in  8  received byte
- tx_valid  out  1  response byte valid
- tx_data  out  8  response byte
- tx_ready  in  1  tx FIFO can accept (driven as !tx_fifo_full)
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion
- mem_addr  out  32  bus address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF on write, 4'h0 on read
- mem_rdata  in  32  read data, valid while mem_ready=1
- drop  out  1  one-cycle pulse: rx byte discarded

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; internal counters 0.
  - Reset mid-transaction drops mem_valid/tx_valid immediately. No response is sent.
- Frame format, multi-byte fields big-endian (MSB first):
  - Write: 0x57, A3 A2 A1 A0, D3 D2 D1 D0.
  - Read: 0x52, A3 A2 A1 A0.
- Response format:
  - Write OK: 0x4B.
  - Read OK: 0x44, D3 D2 D1 D0.
  - Bus timeout: 0x45, for either command.
- States:
  - IDLE:
    - rx 0x57 → ADDR with is_write=1.
    - rx 0x52 → ADDR with is_write=0.
    - Any other byte: ignored, no drop pulse, stay IDLE.
  - ADDR: 4 bytes shifted into addr via a 2-bit byte counter. After the 4th byte: → DATA if is_write, else → BUS.
  - DATA: 4 bytes shifted into wdata. After the 4th byte → BUS.
  - BUS:
    - Entry: mem_valid=1 on the cycle after the final frame byte was strobed.
    - mem_addr/mem_wdata/mem_wstrb are held stable while mem_valid=1.
    - On mem_ready=1: the same edge clears mem_valid, captures mem_rdata (reads) and sets the response → RESP.
    - If mem_ready has not arrived after BUS_TIMEOUT cycles of mem_valid: clear mem_valid, response=0x45 → RESP.
    - mem_ready arriving in the same cycle the counter expires counts as success.
  - RESP:
    - Presents response bytes in order on tx_data with tx_valid=1.
    - A byte advances only on tx_valid&tx_ready.
    - tx_data/tx_valid hold steady while tx_ready=0.
    - After the last byte is accepted: tx_valid=0 the next cycle → IDLE.
- mem_valid and tx_valid are never high in the same cycle.
- Inter-byte timeout:
  - In ADDR/DATA, a counter resets on each rx_valid.
  - When it reaches BYTE_TIMEOUT: discard the partial frame, → IDLE, no response.
- Byte arrival in BUS/RESP: rx_valid while in BUS or RESP discards the byte and pulses drop for exactly 1 cycle. The state is unaffected.
- Unused data: mem_rdata is ignored except on the mem_ready cycle of a read.
- Counter widths: $clog2(param+1). The byte counter wraps 3→0 only on a field transition.
- Throughput: back-to-back frames are accepted. A command byte arriving the cycle after the final response byte is accepted is handled in IDLE.

Test Plan:
- Write: rx 57 80 00 00 04 00 00 00 41; responder returns mem_ready after 3 cycles → mem_addr=32'h80000004, mem_wdata=32'h00000041, mem_wstrb=4'hF, mem_valid held for exactly 3 cycles; tx emits 0x4B.
- Read: rx 52 00 00 10 00; mem_rdata=32'hDEADBEEF with mem_ready on the 1st cycle → mem_wstrb=0; tx emits 44 DE AD BE EF in order.
- Tx backpressure: during the read response, tx_ready=0 for 5 cycles mid-stream → no byte lost or duplicated, tx_data stable while stalled.
- Bus timeout: BUS_TIMEOUT=16, mem_ready never asserted → mem_valid drops after 16 cycles; tx emits 0x45; a following read frame succeeds.
- Frame abort: BYTE_TIMEOUT=50, rx 52 00 00 then 60 idle cycles → no mem_valid, no tx; next frame 52 00 00 00 08 is processed normally. Garbage byte 0x33 in IDLE is ignored.
- Drop and reset: rx byte during BUS → drop pulses 1 cycle, transaction completes. Assert reset while mem_valid=1 → mem_valid=0 immediately, no response.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART debug bridge: parses 'W'/'R' command frames from the rx byte stream, issues one
// picorv32 native-bus transaction per frame and streams the response back to the tx FIFO.
module uart_bus_master #(
  parameter int BYTE_TIMEOUT = 100000,
  parameter int BUS_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        drop
);
  localparam int BTW = $clog2(BYTE_TIMEOUT + 1);
  localparam int MTW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [BTW-1:0] BYTE_LAST = BTW'(BYTE_TIMEOUT - 1);
  localparam logic [MTW-1:0] BUS_LAST  = MTW'(BUS_TIMEOUT - 1);
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_WOK = 8'h4B;
  localparam logic [7:0] RSP_ROK = 8'h44;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t         state_q, state_d;
  logic           is_write_q, is_write_d;
  logic [1:0]     bcnt_q, bcnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [39:0]    resp_q, resp_d;
  logic [2:0]     rlen_q, rlen_d;
  logic [BTW-1:0] btmo_q, btmo_d;
  logic [MTW-1:0] mtmo_q, mtmo_d;
  logic           drop_q, drop_d;

  logic is_cmd, field_done, byte_expired, bus_expired, tx_fire;

  assign is_cmd       = rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD);
  assign field_done   = rx_valid && (bcnt_q == 2'd3);
  assign byte_expired = !rx_valid && (btmo_q == BYTE_LAST);
  assign bus_expired  = (mtmo_q == BUS_LAST);
  assign tx_fire      = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (is_cmd) state_d = S_ADDR;
      S_ADDR: begin
        if (field_done)        state_d = is_write_q ? S_DATA : S_BUS;
        else if (byte_expired) state_d = S_IDLE;
      end
      S_DATA: begin
        if (field_done)        state_d = S_BUS;
        else if (byte_expired) state_d = S_IDLE;
      end
      S_BUS:  if (mem_ready || bus_expired)   state_d = S_RESP;
      S_RESP: if (tx_fire && rlen_q == 3'd1)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_write_d = is_write_q;
    bcnt_d     = bcnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    rlen_d     = rlen_q;
    btmo_d     = btmo_q;
    mtmo_d     = '0;
    drop_d     = rx_valid && (state_q == S_BUS || state_q == S_RESP);
    unique case (state_q)
      S_IDLE: if (is_cmd) begin
        is_write_d = (rx_data == CMD_WR);
        bcnt_d     = '0;
        btmo_d     = '0;
      end
      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          btmo_d = '0;
          bcnt_d = bcnt_q + 2'd1;
          if (state_q == S_ADDR) addr_d  = {addr_q[23:0], rx_data};
          else                   wdata_d = {wdata_q[23:0], rx_data};
        end else begin
          btmo_d = btmo_q + BTW'(1);
        end
      end
      S_BUS: begin
        // A completion on the expiry cycle still wins over the timeout.
        if (mem_ready) begin
          resp_d = is_write_q ? {RSP_WOK, 32'h0} : {RSP_ROK, mem_rdata};
          rlen_d = is_write_q ? 3'd1 : 3'd5;
        end else if (bus_expired) begin
          resp_d = {RSP_ERR, 32'h0};
          rlen_d = 3'd1;
        end else begin
          mtmo_d = mtmo_q + MTW'(1);
        end
      end
      S_RESP: if (tx_fire) begin
        resp_d = {resp_q[31:0], 8'h00};
        rlen_d = rlen_q - 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write_q <= 1'b0;
      bcnt_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      rlen_q     <= '0;
      btmo_q     <= '0;
      mtmo_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      is_write_q <= is_write_d;
      bcnt_q     <= bcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      rlen_q     <= rlen_d;
      btmo_q     <= btmo_d;
      mtmo_q     <= mtmo_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    mem_valid = (state_q == S_BUS);
    tx_valid  = (state_q == S_RESP);
    tx_data   = tx_valid ? resp_q[39:32] : 8'h00;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = (mem_valid && is_write_q) ? 4'hF : 4'h0;
    drop      = drop_q;
  end
endmodule
